// File: rtl/cm3_matrix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cm3_matrix_pkg : HTRANS encodings and port-index width helper        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cm3_matrix_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // Minimum index width able to address n input ports (never below 1).
  function automatic int cm3_port_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cm3_matrix_output_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cm3_matrix_output_arb_if : input-stage requests and arbiter grants   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface cm3_matrix_output_arb_if
  import cm3_matrix_pkg::*;
#(
  parameter int NUM_IN = 3,
  parameter int PORT_W = cm3_port_w(NUM_IN)
);

  logic                  HREADYM;
  logic [NUM_IN-1:0]     sel_op;
  logic [2*NUM_IN-1:0]   trans_op;
  logic [NUM_IN-1:0]     mastlock_op;
  logic [PORT_W-1:0]     addr_in_port;
  logic                  no_port;
  logic [NUM_IN-1:0]     active_op;
  logic [PORT_W-1:0]     data_in_port;
  logic                  data_no_port;

  // master: input stages / output port; slave: the arbiter itself
  modport master (
    output HREADYM, sel_op, trans_op, mastlock_op,
    input  addr_in_port, no_port, active_op, data_in_port, data_no_port
  );

  modport slave (
    input  HREADYM, sel_op, trans_op, mastlock_op,
    output addr_in_port, no_port, active_op, data_in_port, data_no_port
  );

endinterface
`default_nettype wire

// File: rtl/cm3_matrix_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cm3_matrix_rr_pick : rotating-priority picker, starts after rr_ptr   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cm3_matrix_rr_pick #(
  parameter int NUM_IN = 3,
  parameter int PORT_W = 2
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [PORT_W-1:0] rr_ptr_i,
  output logic [PORT_W-1:0] grant_o,
  output logic              any_req_o
);

  function automatic logic [PORT_W-1:0] wrap_idx(input logic [PORT_W-1:0] base, input int off);
    int j;
    j = int'(base) + off;
    if (j >= NUM_IN) j = j - NUM_IN;
    return PORT_W'(j);
  endfunction

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    grant_o   = rr_ptr_i;
    any_req_o = |req_i;
    for (int k = NUM_IN; k >= 1; k--) begin
      if (req_i[wrap_idx(rr_ptr_i, k)]) grant_o = wrap_idx(rr_ptr_i, k);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cm3_matrix_output_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cm3_matrix_output_arb : output-stage arbiter (lock/burst/round robin)|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cm3_matrix_output_arb
  import cm3_matrix_pkg::*;
#(
  parameter int NUM_IN = 3,
  parameter int PORT_W = 2
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  cm3_matrix_output_arb_if.slave  bus
);

  logic [NUM_IN-1:0] req;
  logic [PORT_W-1:0] addr_q, addr_d, rr_q, rr_d, data_in_q, data_in_d, pick;
  logic              no_port_q, no_port_d, lock_q, lock_d, data_no_q, data_no_d;
  logic              any_req, owner_lock, owner_req, pick_lock;
  logic [1:0]        owner_trans;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_req
    assign req[i]           = bus.sel_op[i] & bus.trans_op[2*i+1];
    assign bus.active_op[i] = ~no_port_q & (addr_q == PORT_W'(i));
  end

  cm3_matrix_rr_pick #(
    .NUM_IN (NUM_IN),
    .PORT_W (PORT_W)
  ) u_rr_pick (
    .req_i     (req),
    .rr_ptr_i  (rr_q),
    .grant_o   (pick),
    .any_req_o (any_req)
  );

  always_comb begin
    owner_trans = HTRANS_IDLE;
    owner_lock  = 1'b0;
    owner_req   = 1'b0;
    pick_lock   = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (addr_q == PORT_W'(i)) begin
        owner_trans = bus.trans_op[2*i +: 2];
        owner_lock  = bus.mastlock_op[i];
        owner_req   = req[i];
      end
      if (pick == PORT_W'(i)) pick_lock = bus.mastlock_op[i];
    end
  end

  // Data-phase regs capture the address-phase owner on every accepted edge.
  always_comb begin
    addr_d    = addr_q;
    no_port_d = no_port_q;
    rr_d      = rr_q;
    lock_d    = lock_q;
    data_in_d = data_in_q;
    data_no_d = data_no_q;
    if (bus.HREADYM) begin
      data_in_d = addr_q;
      data_no_d = no_port_q;
      if (lock_q && owner_lock) begin
        no_port_d = 1'b0;
      end else if (!no_port_q && (owner_trans == HTRANS_SEQ || owner_trans == HTRANS_BUSY)) begin
        no_port_d = 1'b0;
        lock_d    = owner_lock & owner_req;
      end else if (any_req) begin
        addr_d    = pick;
        rr_d      = pick;
        no_port_d = 1'b0;
        lock_d    = pick_lock;
      end else begin
        no_port_d = 1'b1;
        lock_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q    <= '0;
      no_port_q <= 1'b1;
      rr_q      <= PORT_W'(NUM_IN - 1);
      lock_q    <= 1'b0;
      data_in_q <= '0;
      data_no_q <= 1'b1;
    end else begin
      addr_q    <= addr_d;
      no_port_q <= no_port_d;
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      data_in_q <= data_in_d;
      data_no_q <= data_no_d;
    end
  end

  assign bus.addr_in_port = addr_q;
  assign bus.no_port      = no_port_q;
  assign bus.data_in_port = data_in_q;
  assign bus.data_no_port = data_no_q;

endmodule
`default_nettype wire
